cdb_writeback_arbiter: RTL and testbench

- Shares the single common data bus (CDB) / PRF write port among the three functional units: ALU, MEM and BR.
- Each FU hands off its completion through a valid/ready handshake into a one-entry holding buffer, one buffer per FU.
- A round-robin arbiter picks one buffered result per cycle and drives a registered CDB broadcast to the PRF, ROB and reservation stations.
- On a branch mispredict, results younger than the mispredicting branch are squashed.

---
 rtl/cdb_writeback_arbiter_if.sv | 44 ++++
 rtl/cdb_writeback_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cdb_writeback_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_writeback_arbiter_if.sv
// Handshake and broadcast bundle between the three FUs, the flush logic
// and the CDB writeback arbiter.
interface cdb_writeback_arbiter_if #(
  parameter int PREG_W = 7,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
);
  logic              alu_valid, mem_valid, br_valid;
  logic              alu_ready, mem_ready, br_ready;
  logic [PREG_W-1:0] alu_pd, mem_pd, br_pd;
  logic [ROB_W-1:0]  alu_rob, mem_rob, br_rob;
  logic [DATA_W-1:0] alu_data, mem_data, br_data;
  logic              alu_wen, mem_wen, br_wen;
  logic              flush;
  logic [ROB_W-1:0]  flush_tag;
  logic [ROB_W-1:0]  rob_head;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_pd;
  logic [ROB_W-1:0]  cdb_rob;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_wen;
  logic [1:0]        cdb_src;
  logic [15:0]       stall_cnt;

  // Producer side: functional units plus the branch/ROB control.
  modport master (
    output alu_valid, mem_valid, br_valid,
    output alu_pd, mem_pd, br_pd, alu_rob, mem_rob, br_rob,
    output alu_data, mem_data, br_data, alu_wen, mem_wen, br_wen,
    output flush, flush_tag, rob_head,
    input  alu_ready, mem_ready, br_ready,
    input  cdb_valid, cdb_pd, cdb_rob, cdb_data, cdb_wen, cdb_src, stall_cnt
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, mem_valid, br_valid,
    input  alu_pd, mem_pd, br_pd, alu_rob, mem_rob, br_rob,
    input  alu_data, mem_data, br_data, alu_wen, mem_wen, br_wen,
    input  flush, flush_tag, rob_head,
    output alu_ready, mem_ready, br_ready,
    output cdb_valid, cdb_pd, cdb_rob, cdb_data, cdb_wen, cdb_src, stall_cnt
  );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// Shares the single CDB / PRF write port among ALU (0), MEM (1) and BR (2).
// Each FU fills a one-entry buffer; a round-robin arbiter picks one buffered
// result per cycle and registers it onto the CDB. Mispredict flushes drop
// buffered and incoming results younger than the branch.
module cdb_writeback_arbiter #(
  parameter int PREG_W = 7,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input logic                   clk,
  input logic                   reset,
  cdb_writeback_arbiter_if.slave bus
);

  logic [2:0]        in_valid, in_wen;
  logic [PREG_W-1:0] in_pd   [3];
  logic [ROB_W-1:0]  in_rob  [3];
  logic [DATA_W-1:0] in_data [3];

  logic [2:0]        buf_valid, buf_wen;
  logic [PREG_W-1:0] buf_pd   [3];
  logic [ROB_W-1:0]  buf_rob  [3];
  logic [DATA_W-1:0] buf_data [3];

  logic [1:0]  rr_ptr;
  logic [2:0]  squash, in_squash, eligible, grant, ready, accept;
  logic [1:0]  grant_idx;
  logic        any_grant, stall;
  logic [2:0]  sum;
  logic [2:0]  pos;

  logic              bcast_valid, bcast_wen;
  logic [PREG_W-1:0] bcast_pd;
  logic [ROB_W-1:0]  bcast_rob;
  logic [DATA_W-1:0] bcast_data;
  logic [1:0]        bcast_src;
  logic [15:0]       stall_count;

  // Age relative to the ROB head wraps naturally in ROB_W bits; strictly
  // greater age than the branch means younger, so the branch survives.
  function automatic logic is_younger(input logic [ROB_W-1:0] tag,
                                      input logic [ROB_W-1:0] btag,
                                      input logic [ROB_W-1:0] head);
    logic [ROB_W-1:0] tag_age, br_age;
    tag_age = tag - head;
    br_age  = btag - head;
    return tag_age > br_age;
  endfunction

  assign in_valid = {bus.br_valid, bus.mem_valid, bus.alu_valid};
  assign in_wen   = {bus.br_wen, bus.mem_wen, bus.alu_wen};
  assign in_pd[0] = bus.alu_pd;    assign in_pd[1] = bus.mem_pd;    assign in_pd[2] = bus.br_pd;
  assign in_rob[0] = bus.alu_rob;  assign in_rob[1] = bus.mem_rob;  assign in_rob[2] = bus.br_rob;
  assign in_data[0] = bus.alu_data; assign in_data[1] = bus.mem_data; assign in_data[2] = bus.br_data;

  // Squash filter over buffered and incoming entries while a flush is active.
  always_comb begin
    squash    = '0;
    in_squash = '0;
    for (int i = 0; i < 3; i++) begin
      squash[i]    = bus.flush && is_younger(buf_rob[i], bus.flush_tag, bus.rob_head);
      in_squash[i] = bus.flush && is_younger(in_rob[i], bus.flush_tag, bus.rob_head);
    end
  end

  assign eligible = buf_valid & ~squash;

  // Round-robin search starting at rr_ptr; first surviving buffer wins.
  always_comb begin
    grant     = '0;
    grant_idx = 2'd0;
    any_grant = 1'b0;
    sum       = '0;
    pos       = '0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, rr_ptr} + 3'(k);
      pos = (sum >= 3'd3) ? sum - 3'd3 : sum;
      if (!any_grant && eligible[pos[1:0]]) begin
        grant[pos[1:0]] = 1'b1;
        grant_idx       = pos[1:0];
        any_grant       = 1'b1;
      end
    end
  end

  // A buffer being drained this cycle can take a new result at the same edge.
  // Stall counts only surviving entries that lose arbitration.
  assign ready  = ~buf_valid | grant;
  assign accept = in_valid & ready;
  assign stall  = |(eligible & ~grant);

  assign bus.alu_ready = ready[0];
  assign bus.mem_ready = ready[1];
  assign bus.br_ready  = ready[2];

  // Holding buffers: load on handshake (dropped if younger than a flushing
  // branch), clear on grant or squash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= '0;
      buf_wen   <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_pd[i]   <= '0;
        buf_rob[i]  <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (accept[i]) begin
          buf_valid[i] <= !in_squash[i];
          buf_wen[i]   <= in_wen[i];
          buf_pd[i]    <= in_pd[i];
          buf_rob[i]   <= in_rob[i];
          buf_data[i]  <= in_data[i];
        end else if (grant[i] || squash[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves past the winner; holds when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ptr <= 2'd0;
    else if (any_grant)
      rr_ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
  end

  // Registered CDB broadcast of the granted entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcast_valid <= 1'b0;
      bcast_wen   <= 1'b0;
      bcast_pd    <= '0;
      bcast_rob   <= '0;
      bcast_data  <= '0;
      bcast_src   <= 2'd0;
    end else begin
      bcast_valid <= any_grant;
      if (any_grant) begin
        bcast_wen  <= buf_wen[grant_idx];
        bcast_pd   <= buf_pd[grant_idx];
        bcast_rob  <= buf_rob[grant_idx];
        bcast_data <= buf_data[grant_idx];
        bcast_src  <= grant_idx;
      end
    end
  end

  // Saturating count of cycles where a surviving entry was left waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end

  assign bus.cdb_valid = bcast_valid;
  assign bus.cdb_wen   = bcast_valid && bcast_wen;
  assign bus.cdb_pd    = bcast_pd;
  assign bus.cdb_rob   = bcast_rob;
  assign bus.cdb_data  = bcast_data;
  assign bus.cdb_src   = bcast_src;
  assign bus.stall_cnt = stall_count;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Self-checking bench for cdb_writeback_arbiter: directed scenarios followed
// by random traffic, all compared against a queue-style reference model.
module tb_cdb_writeback_arbiter;
  localparam int PREG_W = 7;
  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;

  // 100 MHz style free-running clock.
  always #5 clk = ~clk;

  cdb_writeback_arbiter_if #(.PREG_W(PREG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();

  cdb_writeback_arbiter #(.PREG_W(PREG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // FU-side drive values, indexed 0=ALU, 1=MEM, 2=BR.
  logic        drv_valid [3];
  logic [6:0]  drv_pd    [3];
  logic [4:0]  drv_rob   [3];
  logic [31:0] drv_data  [3];
  logic        drv_wen   [3];
  logic        drv_flush;
  logic [4:0]  drv_flush_tag, drv_head;

  // Reference model: what each FU slot holds, whose turn it is, stall total.
  bit          m_held [3];
  logic [6:0]  m_pd   [3];
  logic [4:0]  m_rob  [3];
  logic [31:0] m_data [3];
  logic        m_wen  [3];
  int          m_rr;
  int          m_stall;
  bit          acc    [3];
  bit          e_valid;
  logic [6:0]  e_pd;
  logic [4:0]  e_rob;
  logic [31:0] e_data;
  logic        e_wen;
  int          e_src;

  // Bound the whole run in case something wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int age(input int t, input int head);
    return (t - head + 32) % 32;
  endfunction

  function automatic bit younger_m(input int t);
    return drv_flush && (age(t, int'(drv_head)) > age(int'(drv_flush_tag), int'(drv_head)));
  endfunction

  function automatic logic dut_ready(input int i);
    case (i)
      0:       return bus.alu_ready;
      1:       return bus.mem_ready;
      default: return bus.br_ready;
    endcase
  endfunction

  task automatic drive_bus();
    bus.alu_valid = drv_valid[0]; bus.mem_valid = drv_valid[1]; bus.br_valid = drv_valid[2];
    bus.alu_pd    = drv_pd[0];    bus.mem_pd    = drv_pd[1];    bus.br_pd    = drv_pd[2];
    bus.alu_rob   = drv_rob[0];   bus.mem_rob   = drv_rob[1];   bus.br_rob   = drv_rob[2];
    bus.alu_data  = drv_data[0];  bus.mem_data  = drv_data[1];  bus.br_data  = drv_data[2];
    bus.alu_wen   = drv_wen[0];   bus.mem_wen   = drv_wen[1];   bus.br_wen   = drv_wen[2];
    bus.flush     = drv_flush;
    bus.flush_tag = drv_flush_tag;
    bus.rob_head  = drv_head;
  endtask

  task automatic set_req(input int i, input logic [6:0] pd, input logic [4:0] rob,
                         input logic [31:0] data, input logic wen);
    drv_valid[i] = 1'b1; drv_pd[i] = pd; drv_rob[i] = rob; drv_data[i] = data; drv_wen[i] = wen;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      drv_valid[i] = 1'b0; drv_pd[i] = '0; drv_rob[i] = '0; drv_data[i] = '0; drv_wen[i] = 1'b0;
    end
    drv_flush = 1'b0; drv_flush_tag = '0; drv_head = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_held[i] = 1'b0; acc[i] = 1'b0;
    end
    m_rr = 0; m_stall = 0; e_valid = 1'b0;
  endtask

  // One clock: drive, check readies, advance model, clock, check the CDB.
  task automatic apply_stimulus();
    int win;
    bit rdy [3];
    bit stall;
    drive_bus();
    #1;
    win = -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_rr + k) % 3;
      if (win < 0 && m_held[i] && !younger_m(int'(m_rob[i]))) win = i;
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdy[i] = !m_held[i] || (win == i);
      check_output($sformatf("ready%0d", i), 64'(dut_ready(i)), 64'(rdy[i]));
      if (m_held[i] && !younger_m(int'(m_rob[i])) && win != i) stall = 1'b1;
      acc[i] = drv_valid[i] && rdy[i];
    end
    e_valid = (win >= 0);
    if (win >= 0) begin
      e_pd = m_pd[win]; e_rob = m_rob[win]; e_data = m_data[win]; e_wen = m_wen[win];
      e_src = win;
      m_rr = (win + 1) % 3;
    end
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        m_held[i] = !younger_m(int'(drv_rob[i]));
        m_pd[i] = drv_pd[i]; m_rob[i] = drv_rob[i]; m_data[i] = drv_data[i]; m_wen[i] = drv_wen[i];
      end else if (i == win || (m_held[i] && younger_m(int'(m_rob[i])))) begin
        m_held[i] = 1'b0;
      end
    end
    if (stall && m_stall < 65535) m_stall++;
    @(posedge clk);
    #1;
    check_output("cdb_valid", 64'(bus.cdb_valid), 64'(e_valid));
    if (e_valid) begin
      check_output("cdb_pd",   64'(bus.cdb_pd),   64'(e_pd));
      check_output("cdb_rob",  64'(bus.cdb_rob),  64'(e_rob));
      check_output("cdb_data", 64'(bus.cdb_data), 64'(e_data));
      check_output("cdb_wen",  64'(bus.cdb_wen),  64'(e_wen));
      check_output("cdb_src",  64'(bus.cdb_src),  64'(e_src));
    end else begin
      check_output("cdb_wen_idle", 64'(bus.cdb_wen), 64'd0);
    end
    check_output("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
    for (int i = 0; i < 3; i++)
      if (acc[i]) drv_valid[i] = 1'b0;
  endtask

  // Assert reset asynchronously, check the cleared outputs, release at negedge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_output("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check_output("rst_cdb_pd",    64'(bus.cdb_pd),    64'd0);
    check_output("rst_cdb_rob",   64'(bus.cdb_rob),   64'd0);
    check_output("rst_cdb_data",  64'(bus.cdb_data),  64'd0);
    check_output("rst_cdb_wen",   64'(bus.cdb_wen),   64'd0);
    check_output("rst_cdb_src",   64'(bus.cdb_src),   64'd0);
    check_output("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    idle_inputs();
    drive_bus();
    #1;
    check_output("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    check_output("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    check_output("rst_br_ready",  64'(bus.br_ready),  64'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    drive_bus();
    #2;
    do_reset();

    $display("[TB] single request");
    set_req(0, 7'd5, 5'd3, 32'h12141240, 1'b1);
    apply_stimulus();
    apply_stimulus();
    check_output("single_data", 64'(bus.cdb_data), 64'h12141240);
    check_output("single_src", 64'(bus.cdb_src), 64'd0);
    check_output("single_alu_ready", 64'(bus.alu_ready), 64'd1);
    apply_stimulus();

    $display("[TB] triple collision");
    do_reset();
    set_req(0, 7'd10, 5'd1, 32'hA0A0_0001, 1'b1);
    set_req(1, 7'd11, 5'd2, 32'hB0B0_0002, 1'b1);
    set_req(2, 7'd12, 5'd3, 32'hC0C0_0003, 1'b0);
    apply_stimulus();
    for (int k = 0; k < 3; k++) begin
      apply_stimulus();
      check_output("triple_src", 64'(bus.cdb_src), 64'(k));
    end
    check_output("triple_stall", 64'(bus.stall_cnt), 64'd2);
    apply_stimulus();

    $display("[TB] back-pressure");
    do_reset();
    set_req(1, 7'd40, 5'd9, 32'hDEAD_0040, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (!drv_valid[0]) set_req(0, 7'(20 + k), 5'(10 + k), 32'h0A00_0000 + 32'(k), 1'b1);
      apply_stimulus();
    end
    for (int k = 0; k < 4; k++) apply_stimulus();

    $display("[TB] flush without wrap");
    do_reset();
    set_req(1, 7'd33, 5'd6, 32'h0000_0066, 1'b1);
    set_req(2, 7'd34, 5'd4, 32'h0000_0044, 1'b0);
    apply_stimulus();
    drv_flush = 1'b1; drv_flush_tag = 5'd4; drv_head = 5'd0;
    apply_stimulus();
    check_output("flush_src", 64'(bus.cdb_src), 64'd2);
    check_output("flush_rob", 64'(bus.cdb_rob), 64'd4);
    drv_flush = 1'b0;
    apply_stimulus();
    check_output("flush_squashed", 64'(bus.cdb_valid), 64'd0);

    $display("[TB] flush with wrap");
    do_reset();
    set_req(0, 7'd50, 5'd1, 32'h0000_0101, 1'b1);
    set_req(1, 7'd51, 5'd30, 32'h0000_3030, 1'b1);
    apply_stimulus();
    drv_flush = 1'b1; drv_flush_tag = 5'd31; drv_head = 5'd30;
    apply_stimulus();
    check_output("wrap_src", 64'(bus.cdb_src), 64'd1);
    check_output("wrap_rob", 64'(bus.cdb_rob), 64'd30);
    drv_flush = 1'b0;
    apply_stimulus();
    check_output("wrap_squashed", 64'(bus.cdb_valid), 64'd0);

    $display("[TB] reset mid-operation");
    do_reset();
    set_req(0, 7'd60, 5'd7, 32'h6000_0000, 1'b1);
    set_req(1, 7'd61, 5'd8, 32'h6100_0000, 1'b1);
    set_req(2, 7'd62, 5'd9, 32'h6200_0000, 1'b1);
    apply_stimulus();
    do_reset();
    for (int k = 0; k < 10; k++) apply_stimulus();
    check_output("post_reset_quiet", 64'(bus.cdb_valid), 64'd0);

    $display("[TB] random traffic");
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++)
        if (!drv_valid[i] && $urandom_range(0, 99) < 55)
          set_req(i, 7'($urandom), 5'($urandom), $urandom, 1'($urandom));
      drv_flush     = ($urandom_range(0, 99) < 15);
      drv_flush_tag = 5'($urandom);
      drv_head      = 5'($urandom);
      apply_stimulus();
    end
    drv_flush = 1'b0;
    for (int k = 0; k < 6; k++) apply_stimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
